bus_arbiter: RTL and testbench

Round-robin arbiter for the shared system bus. It sits between the bus-master DMA blocks (camera grabber, other DMA masters) and the bus. It hands out exclusive bus ownership through request/grant pairs and tracks each transaction by watching the shared begin/end strobes. Two watchdogs keep the bus from being hung: one for a master that never starts after being granted, and one for a transaction that never ends.

---
 rtl/bus_arbiter_pkg.sv | 36 +++
 rtl/bus_arbiter_rr_picker.sv | 70 +++++++
 rtl/bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared definitions for the round-robin bus arbiter:
//               FSM state encoding, the master-index width, the maximum
//               master count and a constant clog2 helper.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  // Upper bound on the number of requesters; the master index is sized for it.
  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Smallest r such that 2**r >= value; used to size the watchdog counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rrPicker
// Description : Combinational round-robin selector. Rotates the request
//               vector so that the master after last_grant sits at bit 0,
//               priority-encodes the lowest set bit, then rotates the result
//               back into an absolute master index and a one-hot grant.
// Ports       : request     in  N      request vector
//               last_grant  in  3      index of the previous winner
//               any_request out 1      at least one request bit set
//               grant       out N      one-hot winner (zero if none)
//               grant_index out 3      index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module rrPicker
  import bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any_request,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_index
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [2*N-1:0]  doubled;
  logic [N-1:0]    rotated;
  logic [IDX_W:0]  start;
  logic [IDX_W:0]  offset;
  logic [IDX_W:0]  sum;

  always_comb begin
    any_request = |request;

    // Search starts one past the previous winner, wrapping at N.
    start = {1'b0, last_grant} + (IDX_W + 1)'(1);
    if (start >= N_W) begin
      start = '0;
    end

    // Rotate right by 'start' using a doubled copy so bits wrap around.
    doubled = {request, request};
    rotated = N'(doubled >> start);

    // Lowest set bit of the rotated vector wins (descending loop, last write wins).
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = (IDX_W + 1)'(i);
      end
    end

    // Rotate back: start + offset < 2N, so a single conditional subtract suffices.
    sum = start + offset;
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    grant_index = sum[IDX_W-1:0];

    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = any_request && (sum == (IDX_W + 1)'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the shared system bus with a grant
//               watchdog (granted master never begins) and a bus watchdog
//               (transaction never ends). Every output is registered or
//               decoded from registered state only.
// Ports       : clock              in  1  system clock, rising edge
//               reset              in  1  synchronous, active-high
//               requestBus         in  N  per-master bus request
//               busGrant           out N  one-hot or zero grant
//               beginTransactionIn in  1  shared begin strobe
//               endTransactionIn   in  1  shared end strobe
//               busErrorOut        out 1  pulse: transaction timed out
//               timeoutOut         out 1  pulse: grant timed out
//               activeMaster       out 3  current or last granted master
//               busIdle            out 1  arbiter is idle
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int nrOfMasters  = 4,
  parameter int grantTimeout = 16,
  parameter int busTimeout   = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nrOfMasters-1:0] requestBus,
  output logic [nrOfMasters-1:0] busGrant,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  output logic                   busErrorOut,
  output logic                   timeoutOut,
  output logic [IDX_W-1:0]       activeMaster,
  output logic                   busIdle
);

  localparam int WAIT_W = clog2(grantTimeout + 1);
  localparam int BUSY_W = clog2(busTimeout + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(grantTimeout - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST  = BUSY_W'(busTimeout - 1);
  localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(nrOfMasters - 1);

  arb_state_t              state, state_next;
  logic [IDX_W-1:0]        last_grant, last_grant_next;
  logic [WAIT_W-1:0]       wait_count, wait_count_next;
  logic [BUSY_W-1:0]       busy_count, busy_count_next;
  logic [nrOfMasters-1:0]  grant_next;
  logic [IDX_W-1:0]        active_next;
  logic                    bus_error_next;
  logic                    timeout_next;

  logic                    pick_any;
  logic [nrOfMasters-1:0]  pick_grant;
  logic [IDX_W-1:0]        pick_index;

  rrPicker #(
    .N (nrOfMasters)
  ) u_picker (
    .request     (requestBus),
    .last_grant  (last_grant),
    .any_request (pick_any),
    .grant       (pick_grant),
    .grant_index (pick_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= LAST_RESET;
      wait_count   <= '0;
      busy_count   <= '0;
      busGrant     <= '0;
      activeMaster <= '0;
      busErrorOut  <= 1'b0;
      timeoutOut   <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      wait_count   <= wait_count_next;
      busy_count   <= busy_count_next;
      busGrant     <= grant_next;
      activeMaster <= active_next;
      busErrorOut  <= bus_error_next;
      timeoutOut   <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    wait_count_next = wait_count;
    busy_count_next = busy_count;
    grant_next      = busGrant;
    active_next     = activeMaster;
    bus_error_next  = 1'b0;
    timeout_next    = 1'b0;

    case (state)
      ST_IDLE: begin
        grant_next      = '0;
        wait_count_next = '0;
        busy_count_next = '0;
        if (pick_any) begin
          grant_next      = pick_grant;
          last_grant_next = pick_index;
          active_next     = pick_index;
          state_next      = ST_GRANTED;
        end
      end

      ST_GRANTED: begin
        // Request may already be gone here; the grant only ends via begin or timeout.
        // Begin takes priority, so a simultaneous end strobe is ignored.
        if (beginTransactionIn) begin
          wait_count_next = '0;
          state_next      = ST_BUSY;
        end else if (wait_count == WAIT_LAST) begin
          wait_count_next = '0;
          grant_next      = '0;
          timeout_next    = 1'b1;
          state_next      = ST_RELEASE;
        end else begin
          wait_count_next = wait_count + WAIT_W'(1);
        end
      end

      ST_BUSY: begin
        // A real end on the expiry cycle counts as a normal release.
        if (endTransactionIn) begin
          busy_count_next = '0;
          grant_next      = '0;
          state_next      = ST_RELEASE;
        end else if (busy_count == BUSY_LAST) begin
          busy_count_next = '0;
          grant_next      = '0;
          bus_error_next  = 1'b1;
          state_next      = ST_RELEASE;
        end else begin
          busy_count_next = busy_count + BUSY_W'(1);
        end
      end

      ST_RELEASE: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end

      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busIdle = (state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. Transactions are driven
//               cycle by cycle; the expected winner comes from a round-robin
//               model over the request mask, and expected grant length,
//               timeouts and release timing come from plain arithmetic on
//               the begin delay and busy length of each transaction.
// Ports       : (none)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int GT = 16;
  localparam int BT = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] requestBus = '0;
  logic         beginTransactionIn = 1'b0;
  logic         endTransactionIn = 1'b0;
  logic [N-1:0] busGrant;
  logic         busErrorOut;
  logic         timeoutOut;
  logic [2:0]   activeMaster;
  logic         busIdle;

  int errors = 0;
  int checks = 0;
  int model_last = N - 1;

  bus_arbiter #(
    .nrOfMasters  (N),
    .grantTimeout (GT),
    .busTimeout   (BT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .requestBus         (requestBus),
    .busGrant           (busGrant),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .busErrorOut        (busErrorOut),
    .timeoutOut         (timeoutOut),
    .activeMaster       (activeMaster),
    .busIdle            (busIdle)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Round-robin rule: first requester found walking upward from last winner + 1.
  function automatic int predict(input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (model_last + i) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    requestBus = '0;
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_last = N - 1;
  endtask

  // One full transaction starting in an idle cycle. d = grant cycles before
  // begin is sampled (d > GT means never), len = busy cycles before end
  // (len > BT means the bus watchdog fires). Ends in the following idle cycle.
  task automatic run_txn(input logic [N-1:0] mask, input int d, input int len,
                         input bit hold, input bit both, output int got);
    int exp_idx;
    logic [N-1:0] exp_grant;
    bit exp_to;
    bit exp_err;
    int nb;
    exp_idx = predict(mask);
    model_last = exp_idx;
    exp_grant = '0;
    exp_grant[exp_idx] = 1'b1;
    exp_to = (d > GT);
    exp_err = !exp_to && (len > BT);

    requestBus = mask;
    tick();
    got = int'(activeMaster);
    checks++;
    if (busGrant !== exp_grant || activeMaster !== 3'(exp_idx) || busIdle !== 1'b0) begin
      errors++;
      $display("FAIL grant_issue: grant=%b master=%0d idle=%b, required grant=%b master=%0d idle=0",
               busGrant, activeMaster, busIdle, exp_grant, exp_idx);
    end
    if (!hold) requestBus = '0;

    if (exp_to) begin
      for (int g = 2; g <= GT; g++) begin
        tick();
        checks++;
        if (busGrant !== exp_grant || timeoutOut !== 1'b0) begin
          errors++;
          $display("FAIL grant_wait cycle %0d: grant=%b to=%b, required grant=%b to=0",
                   g, busGrant, timeoutOut, exp_grant);
        end
      end
    end else begin
      for (int g = 1; g <= d; g++) begin
        if (g > 1) begin
          tick();
          checks++;
          if (busGrant !== exp_grant || timeoutOut !== 1'b0) begin
            errors++;
            $display("FAIL grant_hold cycle %0d: grant=%b to=%b, required grant=%b to=0",
                     g, busGrant, timeoutOut, exp_grant);
          end
        end
        if (g == d) begin
          beginTransactionIn = 1'b1;
          endTransactionIn = both;
        end
      end
      tick();
      beginTransactionIn = 1'b0;
      endTransactionIn = 1'b0;
      nb = (len < BT) ? len : BT;
      for (int b = 1; b <= nb; b++) begin
        if (b > 1) tick();
        checks++;
        if (busGrant !== exp_grant || busErrorOut !== 1'b0 || busIdle !== 1'b0) begin
          errors++;
          $display("FAIL busy cycle %0d: grant=%b err=%b idle=%b, required grant=%b err=0 idle=0",
                   b, busGrant, busErrorOut, busIdle, exp_grant);
        end
        if (b == len) endTransactionIn = 1'b1;
      end
    end

    tick();
    endTransactionIn = 1'b0;
    checks++;
    if (busGrant !== '0 || timeoutOut !== exp_to || busErrorOut !== exp_err || busIdle !== 1'b0) begin
      errors++;
      $display("FAIL release: grant=%b to=%b err=%b idle=%b, required grant=0 to=%b err=%b idle=0",
               busGrant, timeoutOut, busErrorOut, busIdle, exp_to, exp_err);
    end

    tick();
    checks++;
    if (busGrant !== '0 || timeoutOut !== 1'b0 || busErrorOut !== 1'b0 || busIdle !== 1'b1 ||
        activeMaster !== 3'(exp_idx)) begin
      errors++;
      $display("FAIL idle_gap: grant=%b to=%b err=%b idle=%b master=%0d, required 0 0 0 1 master=%0d",
               busGrant, timeoutOut, busErrorOut, busIdle, activeMaster, exp_idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    requestBus = '1;
    tick();
    tick();
    checks++;
    if (busGrant !== '0 || busErrorOut !== 1'b0 || timeoutOut !== 1'b0 ||
        activeMaster !== 3'd0 || busIdle !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: grant=%b err=%b to=%b master=%0d idle=%b, required 0 0 0 0 1",
               busGrant, busErrorOut, timeoutOut, activeMaster, busIdle);
    end
    requestBus = '0;
    reset = 1'b0;
    model_last = N - 1;
    tick();
    checks++;
    if (busGrant !== '0 || busIdle !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_request: grant=%b idle=%b, required grant=0 idle=1", busGrant, busIdle);
    end
  endtask

  task automatic test_camera();
    int got;
    do_reset();
    run_txn(4'b0001, 2, 8, 1'b0, 1'b0, got);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL camera_master: got %0d, required 0", got);
    end
  endtask

  task automatic test_fairness();
    int got;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b1111, 2, 4, 1'b1, 1'b0, got);
      checks++;
      if (got !== exp_order[k]) begin
        errors++;
        $display("FAIL fairness_order[%0d]: got %0d, required %0d", k, got, exp_order[k]);
      end
    end
    requestBus = '0;
  endtask

  task automatic test_grant_timeout();
    int got;
    do_reset();
    run_txn(4'b0100, GT + 1, 1, 1'b0, 1'b0, got);
    run_txn(4'b0110, 3, 2, 1'b0, 1'b0, got);
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL after_grant_timeout_master: got %0d, required 1", got);
    end
  endtask

  task automatic test_bus_timeout();
    int got;
    run_txn(4'b1000, 1, BT + 8, 1'b0, 1'b0, got);
  endtask

  task automatic test_end_at_timeout();
    int got;
    run_txn(4'b0010, 2, BT, 1'b0, 1'b0, got);
  endtask

  task automatic test_begin_end_together();
    int got;
    run_txn(4'b0001, 3, 5, 1'b0, 1'b1, got);
  endtask

  task automatic test_mid_reset();
    int got;
    do_reset();
    requestBus = 4'b0010;
    tick();
    checks++;
    if (activeMaster !== 3'd1 || busGrant !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset_grant: grant=%b master=%0d, required grant=0010 master=1",
               busGrant, activeMaster);
    end
    requestBus = '0;
    beginTransactionIn = 1'b1;
    tick();
    beginTransactionIn = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busGrant !== '0 || busIdle !== 1'b1 || activeMaster !== 3'd0 ||
        busErrorOut !== 1'b0 || timeoutOut !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: grant=%b idle=%b master=%0d err=%b to=%b, required 0 1 0 0 0",
               busGrant, busIdle, activeMaster, busErrorOut, timeoutOut);
    end
    reset = 1'b0;
    model_last = N - 1;
    run_txn(4'b1001, 2, 3, 1'b0, 1'b0, got);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL post_reset_master: got %0d, required 0", got);
    end
  endtask

  task automatic test_random();
    int got;
    logic [N-1:0] mask;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      run_txn(mask, int'($urandom_range(1, GT + 2)), int'($urandom_range(1, BT + 3)),
              bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), got);
    end
    requestBus = '0;
  endtask

  initial begin
    test_reset();
    test_camera();
    test_fairness();
    test_grant_timeout();
    test_bus_timeout();
    test_end_at_timeout();
    test_begin_end_together();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
